// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage types: ALU function codes and the multiply/divide operation set.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alufunc_t;

    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_t;

    localparam int MDU_WORD_BITS = 32;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic mdu_is_mulh(input mdu_op_t op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
    endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Operand preparation for muldiv_unit: word truncation/extension, magnitudes,
// result/remainder sign capture and divide corner-case detection.
module mdu_operand_prep
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int WORD_EN = 1
) (
    input  mdu_op_t          op,
    input  logic             word,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             word_eff,
    output logic [XLEN-1:0]  a_ext,
    output logic [XLEN-1:0]  mag_a,
    output logic [XLEN-1:0]  mag_b,
    output logic             neg_res,
    output logic             neg_rem,
    output logic             b_zero,
    output logic             ovf
);

    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD =
        {{(XLEN-MDU_WORD_BITS){1'b0}}, 1'b1, {(MDU_WORD_BITS-1){1'b0}}};

    logic            a_sgn, b_sgn, sign_a, sign_b;
    logic [XLEN-1:0] b_ext;

    always_comb begin
        // High-half multiplies have no W form, so word is ignored for them.
        word_eff = (WORD_EN != 0) && word && !mdu_is_mulh(op);
        a_sgn    = op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_sgn    = op inside {MDU_MULH, MDU_DIV, MDU_REM};
        if (word_eff) begin
            a_ext = {{(XLEN-MDU_WORD_BITS){a_sgn & a[MDU_WORD_BITS-1]}}, a[MDU_WORD_BITS-1:0]};
            b_ext = {{(XLEN-MDU_WORD_BITS){b_sgn & b[MDU_WORD_BITS-1]}}, b[MDU_WORD_BITS-1:0]};
        end else begin
            a_ext = a;
            b_ext = b;
        end
        sign_a  = a_sgn & a_ext[XLEN-1];
        sign_b  = b_sgn & b_ext[XLEN-1];
        mag_a   = sign_a ? -a_ext : a_ext;
        mag_b   = sign_b ? -b_ext : b_ext;
        neg_res = sign_a ^ sign_b;
        neg_rem = sign_a;
        b_zero  = (b_ext == '0);
        // The most-negative value is its own magnitude, which makes this test cheap.
        ovf     = (op inside {MDU_DIV, MDU_REM}) && sign_a && sign_b &&
                  (mag_b == XLEN'(1)) && (mag_a == (word_eff ? MIN_WORD : MIN_FULL));
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider for RV64M including W forms.
// Define MDU_BYPASS_EN to retire divide-by-zero, signed overflow and zero-operand multiplies without iterating.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int WORD_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  mdu_op_t          op,
    input  logic             word,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state, state_nx;
    mdu_op_t           op_r;
    logic              word_r, neg_r, negrem_r, bz_r, ovf_r;
    logic [XLEN-1:0]   aext_r, md_r, sh_r;
    logic [2*XLEN-1:0] acc_r, acc_nx;
    logic [XLEN-1:0]   sh_nx;
    logic [XLEN:0]     r2, diff;
    logic [CW-1:0]     cnt_r;

    logic              pr_word, pr_neg, pr_negrem, pr_bz, pr_ovf, accept, bypass;
    logic [XLEN-1:0]   pr_aext, pr_maga, pr_magb, sh_init;

    mdu_operand_prep #(.XLEN(XLEN), .WORD_EN(WORD_EN)) u_prep (
        .op       (op),
        .word     (word),
        .a        (a),
        .b        (b),
        .word_eff (pr_word),
        .a_ext    (pr_aext),
        .mag_a    (pr_maga),
        .mag_b    (pr_magb),
        .neg_res  (pr_neg),
        .neg_rem  (pr_negrem),
        .b_zero   (pr_bz),
        .ovf      (pr_ovf)
    );

    // Divide corner cases are forced here, so iteration results never need to be right for them.
    function automatic logic [XLEN-1:0] fixup(
        input mdu_op_t f_op, input logic f_word, input logic f_neg, input logic f_negrem,
        input logic f_bz, input logic f_ovf, input logic [XLEN-1:0] f_aext,
        input logic [2*XLEN-1:0] f_prod, input logic [XLEN-1:0] f_quo, input logic [XLEN-1:0] f_rem);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r, res;
        p = f_neg    ? -f_prod : f_prod;
        q = f_neg    ? -f_quo  : f_quo;
        r = f_negrem ? -f_rem  : f_rem;
        if (f_bz) begin
            q = '1;
            r = f_aext;
        end
        if (f_ovf) begin
            q = f_aext;
            r = '0;
        end
        case (f_op)
            MDU_MUL:                         res = p[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res = p[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               res = q;
            default:                         res = r;
        endcase
        if (f_word) res = {{(XLEN-MDU_WORD_BITS){res[MDU_WORD_BITS-1]}}, res[MDU_WORD_BITS-1:0]};
        return res;
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && !flush;
    assign sh_init   = mdu_is_div(op) ? pr_maga : pr_magb;

`ifdef MDU_BYPASS_EN
    assign bypass = mdu_is_div(op) ? (pr_bz || pr_ovf) : (pr_bz || pr_maga == '0);
`else
    assign bypass = 1'b0;
`endif

    // One iteration: sh supplies multiplier bits MSB first, or dividend bits in / quotient bits out.
    always_comb begin
        r2     = {acc_r[XLEN-1:0], sh_r[XLEN-1]};
        diff   = r2 - {1'b0, md_r};
        sh_nx  = {sh_r[XLEN-2:0], 1'b0};
        acc_nx = {acc_r[2*XLEN-2:0], 1'b0} + (sh_r[XLEN-1] ? {{XLEN{1'b0}}, md_r} : '0);
        if (mdu_is_div(op_r)) begin
            if (!diff[XLEN]) begin
                acc_nx   = {{XLEN{1'b0}}, diff[XLEN-1:0]};
                sh_nx[0] = 1'b1;
            end else begin
                acc_nx   = {{XLEN{1'b0}}, r2[XLEN-1:0]};
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = bypass ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt_r == '0) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_r     <= MDU_MUL;
            word_r   <= 1'b0;
            neg_r    <= 1'b0;
            negrem_r <= 1'b0;
            bz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            aext_r   <= '0;
            md_r     <= '0;
            sh_r     <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_r     <= op;
                word_r   <= pr_word;
                neg_r    <= pr_neg;
                negrem_r <= pr_negrem;
                bz_r     <= pr_bz;
                ovf_r    <= pr_ovf;
                aext_r   <= pr_aext;
                md_r     <= mdu_is_div(op) ? pr_magb : pr_maga;
                // W forms run 32 steps, so their operand starts at the top of sh.
                sh_r     <= pr_word ? (sh_init << (XLEN - MDU_WORD_BITS)) : sh_init;
                acc_r    <= '0;
                cnt_r    <= pr_word ? CW'(MDU_WORD_BITS - 1) : CW'(XLEN - 1);
                if (bypass)
                    result <= fixup(op, pr_word, pr_neg, pr_negrem, pr_bz, pr_ovf, pr_aext,
                                    '0, '0, '0);
            end else if (state == S_BUSY && !flush) begin
                acc_r <= acc_nx;
                sh_r  <= sh_nx;
                cnt_r <= cnt_r - 1'b1;
                if (cnt_r == '0)
                    result <= fixup(op_r, word_r, neg_r, negrem_r, bz_r, ovf_r, aext_r,
                                    acc_nx, sh_nx, acc_nx[XLEN-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 128-bit arithmetic reference model, directed corner cases and random ops.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk, reset, in_valid, in_ready, word_i, flush, out_valid, rdy;
    mdu_op_t     op_i;
    logic [63:0] a_i, b_i, result;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          op_id = 0;
    logic        seen = 1'b0;
    logic [63:0] held = '0;

    muldiv_unit #(.XLEN(64), .WORD_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .word      (word_i),
        .a         (a_i),
        .b         (b_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (rdy),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: RV64M semantics computed on 128-bit integers.
    function automatic logic [63:0] model(input mdu_op_t o, input bit w, input logic [63:0] x, input logic [63:0] y);
        bit                  we;
        logic signed [127:0] xs, ys;
        logic [127:0]        xu, yu, r;
        logic [63:0]         res;
        we = w && !(o inside {MDU_MULH, MDU_MULHSU, MDU_MULHU});
        if (we) begin
            xs = {{96{x[31]}}, x[31:0]};
            ys = {{96{y[31]}}, y[31:0]};
            xu = {96'd0, x[31:0]};
            yu = {96'd0, y[31:0]};
        end else begin
            xs = {{64{x[63]}}, x};
            ys = {{64{y[63]}}, y};
            xu = {64'd0, x};
            yu = {64'd0, y};
        end
        case (o)
            MDU_MUL:    begin r = xu * yu; res = r[63:0]; end
            MDU_MULH:   begin r = xs * ys; res = r[127:64]; end
            MDU_MULHSU: begin r = xs * $signed(yu); res = r[127:64]; end
            MDU_MULHU:  begin r = xu * yu; res = r[127:64]; end
            MDU_DIV:    begin if (yu == '0) res = '1; else begin r = xs / ys; res = r[63:0]; end end
            MDU_DIVU:   begin if (yu == '0) res = '1; else begin r = xu / yu; res = r[63:0]; end end
            MDU_REM:    begin if (yu == '0) res = xs[63:0]; else begin r = xs % ys; res = r[63:0]; end end
            default:    begin if (yu == '0) res = xu[63:0]; else begin r = xu % yu; res = r[63:0]; end end
        endcase
        if (we) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic int exp_lat(input mdu_op_t o, input bit w, input logic [63:0] x, input logic [63:0] y);
        bit we = w && !(o inside {MDU_MULH, MDU_MULHSU, MDU_MULHU});
        int n = we ? 32 : 64;
`ifdef MDU_BYPASS_EN
        logic [63:0] xe = we ? {32'd0, x[31:0]} : x;
        logic [63:0] ye = we ? {32'd0, y[31:0]} : y;
        bit isdiv = o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
        bit ovf = (o inside {MDU_DIV, MDU_REM}) &&
                  (we ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                      : (x == 64'h8000_0000_0000_0000 && y == '1));
        if (isdiv ? (ye == '0 || ovf) : (xe == '0 || ye == '0)) return 1;
`endif
        return n + 1;
    endfunction

    task automatic issue(input mdu_op_t o, input bit w, input logic [63:0] x, input logic [63:0] y, input bit expect_out);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            return;
        end
        op_i = o; word_i = w; a_i = x; b_i = y; in_valid = 1'b1;
        if (expect_out) begin
            sbq.push_back('{res: model(o, w, x, y), cyc: cyc + exp_lat(o, w, x, y), id: op_id});
            op_id++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 300) begin tick(); n++; end
        if (sbq.size() != 0 || !in_ready) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results pending, in_ready=%0b", sbq.size(), in_ready);
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {$urandom, 32'h8000_0000};
            4:       return {$urandom, 32'hFFFF_FFFF};
            5:       return 64'($urandom_range(1, 9));
            6:       return -64'($urandom_range(1, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: checks each result and its arrival cycle, and that DONE holds steady while stalled.
    always @(negedge clk) begin
        if (reset) begin
            seen <= 1'b0;
        end else if (out_valid) begin
            check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
            if (!seen) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: result %h with no operation pending", result);
                end else begin
                    check($sformatf("op%0d_result", sbq[0].id), result, sbq[0].res);
                    check($sformatf("op%0d_latency", sbq[0].id), 64'(cyc), 64'(sbq[0].cyc));
                    void'(sbq.pop_front());
                end
                held <= result;
            end else begin
                check("result_stable", result, held);
            end
            seen <= !rdy;
        end
    end

    initial begin
        bit saw;
        int n;
        reset = 1'b1; in_valid = 1'b0; op_i = MDU_MUL; word_i = 1'b0;
        a_i = '0; b_i = '0; flush = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);

        issue(MDU_MUL,  1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        issue(MDU_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(MDU_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
        issue(MDU_DIVU, 1'b0, 64'h1234, 64'd0, 1'b1);
        issue(MDU_REMU, 1'b0, 64'h1234, 64'd0, 1'b1);
        issue(MDU_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        issue(MDU_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        issue(MDU_DIV,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF, 1'b1);
        issue(MDU_MULH, 1'b1, 64'h4000_0000_0000_0000, 64'd6, 1'b1);
        drain();

        rdy = 1'b0;
        issue(MDU_MULHU, 1'b0, '1, '1, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) tick();
        check("stall_held_valid", {63'd0, out_valid}, 64'd1);
        rdy = 1'b1;
        tick();
        check("stall_released", {63'd0, out_valid}, 64'd0);
        drain();

        op_i = MDU_MUL; a_i = 64'd5; b_i = 64'd7; word_i = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 40; i++)
            issue(mdu_op_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
        drain();

        issue(MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd3, 1'b0);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        saw = 1'b0;
        repeat (80) begin tick(); saw |= out_valid; end
        check("flush_no_out_valid", {63'd0, saw}, 64'd0);

        issue(MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd3, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_result", result, 64'd0);
        saw = 1'b0;
        repeat (80) begin tick(); saw |= out_valid; end
        check("midreset_no_out_valid", {63'd0, saw}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, iterative integer multiply/divide unit for the execute stage. Replaces the separate fixed-width multiplier and signed/unsigned divider instances with one shared shift-add / restoring-division datapath. Covers all eight RV64M operations plus 32-bit word mode, handles every divide corner case internally, and talks to the pipeline through valid/ready handshakes on both sides instead of a bubble signal.

## Interface
- XLEN, 64: operand/result width; even, ≥ 32
- WORD_EN, 1: 1 enables `word` (32-bit ops); 0 ties word mode off
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit idle, can accept
- op  in  mdu_op_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- word  in  1  32-bit W-form operation
- a, b  in  XLEN  operands: rs1, rs2
- flush  in  1  discard any in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  final result

## Operation
- FSM with three states: IDLE, BUSY, DONE; reset → IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, latch op/word, prepare operands, go to BUSY. Iteration count is N = 32 if word, else XLEN.
- Operand prep: in word mode, take a[31:0], b[31:0], sign-extend for signed ops, zero-extend for unsigned ops. Signed operands become magnitudes; result sign is recorded. MULHSU: only a is signed.
- BUSY: one bit per cycle. Multiply: shift-add into a 2·XLEN accumulator. Divide: restoring step, quotient and remainder registers. A counter runs down from N-1; at 0 apply sign fix-up and go to DONE.
- Sign fix-up: product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
- Result selection: MUL → low XLEN. MULH* → high XLEN. DIV*/REM* → quotient/remainder.
- Word mode: result = sign-extended bit [31] of the 32-bit result. word with MULH/MULHSU/MULHU is treated as word=0. With WORD_EN=0, word is ignored.
- Divide by zero: quotient = all ones, remainder = dividend (after word truncation/extension).
- Signed overflow (most-negative ÷ -1): quotient = dividend, remainder = 0.
- DONE: out_valid=1, result held stable. On out_ready, go to IDLE. A new operation is not accepted in the same cycle (in_ready=0 in DONE).
- flush: checked in every state, highest priority. The next state is IDLE, no out_valid for the discarded operation, and in_ready=1 the next cycle. A flush together with in_valid in IDLE does not accept the operation.
- reset mid-operation: same as flush; all registers cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0; internal counter and accumulators 0.
- Accept in cycle t → out_valid rises in cycle t+N+1: 65 for XLEN=64 full-width ops, 33 for word ops.
- Special-case bypass (see Configuration) → out_valid in cycle t+1.
- All outputs are registered; no combinational path from in_valid/a/b to result or out_valid.
- in_ready depends only on state, so it never depends on in_valid combinationally.
- Back-to-back throughput: one operation per N+2 cycles with out_ready held high.

## Configuration
- MDU_BYPASS_EN defined:
  - Divide by zero, signed overflow, and multiply with either operand zero skip BUSY: IDLE → DONE directly, with the correct result.
- Not defined:
  - These cases run the full N iterations.
  - Results are still correct: the fixed values come from fix-up logic, not from the iteration.

## Structure
- The mdu_op_t enum goes in the shared common package, next to alufunc_t. An MDU_WORD_BITS=32 constant goes there too.
- The FSM state enum stays local to the module.
- One sub-module, `mdu_operand_prep`: combinational word truncation/extension, magnitude, and sign capture. It is instantiated once on the input side.
- The iteration datapath and FSM live in muldiv_unit.

## Test plan
- MUL a=3, b=-5 (XLEN=64), out_ready=1 → result 0xFFFF_FFFF_FFFF_FFF1; out_valid exactly 65 cycles after accept.
- DIV a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD. REM, same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=0x1234, b=0 → all ones. REMU → 0x1234. Latency 1 with MDU_BYPASS_EN, 65 without.
- DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0. Word DIVW a=0x1_8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 after 33 cycles.
- MULHU a=b=all ones → 0xFFFF_FFFF_FFFF_FFFE. Hold out_ready=0 for 3 cycles: out_valid and result stay stable, in_ready=0 throughout.
- Start DIV, assert flush at iteration 10 → next cycle in_ready=1, out_valid never rises. Repeat with reset instead of flush → same outcome, result=0.
